// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle.
// Purpose: groups the instruction-memory port, the decode handshake and the
// execute redirect path of the fetch stage into one connection.
// Signals (named from the fetch stage's point of view):
//   o_imem_addr   byte address presented to instruction memory (= PC)
//   i_imem_inst   word returned combinationally for o_imem_addr
//   o_inst/o_pc   registered instruction and its fetch address
//   o_valid       o_inst/o_pc hold a live instruction
//   i_ready       decode accepts o_inst this cycle
//   i_redirect    execute requests a PC change
//   i_redirect_pc redirect target
//   o_misaligned  sticky fault: last redirect target not 4-byte aligned
// Modports: master = fetch stage, slave = memory/decode/execute side.

`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

interface inst_fetch_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH-1:0]  o_imem_addr;
    logic [`INST_WIDTH-1:0] i_imem_inst;
    logic [`INST_WIDTH-1:0] o_inst;
    logic [ADDR_WIDTH-1:0]  o_pc;
    logic                   o_valid;
    logic                   i_ready;
    logic                   i_redirect;
    logic [ADDR_WIDTH-1:0]  i_redirect_pc;
    logic                   o_misaligned;

    modport master (
        output o_imem_addr, o_inst, o_pc, o_valid, o_misaligned,
        input  i_imem_inst, i_ready, i_redirect, i_redirect_pc
    );

    modport slave (
        input  o_imem_addr, o_inst, o_pc, o_valid, o_misaligned,
        output i_imem_inst, i_ready, i_redirect, i_redirect_pc
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage.
// Purpose: holds the PC, presents it to a combinational-read instruction
// memory, registers the returned word for decode behind a valid/ready
// handshake, and applies redirects from execute. A misaligned redirect target
// parks the stage in FAULT (no fetching) until an aligned redirect or reset.
// Ports:
//   i_clk    clock, all state updates on the rising edge
//   i_rst_n  synchronous active-low reset
//   bus      inst_fetch_if.master (memory port, decode handshake, redirect)

`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module inst_fetch #(
    parameter int                           MEM_SIZE = 1024,
    parameter logic [$clog2(MEM_SIZE)-1:0]  RESET_PC = '0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    inst_fetch_if.master  bus
);
    localparam int ADDR_WIDTH = $clog2(MEM_SIZE);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [`INST_WIDTH-1:0] inst_q, inst_d;
    logic [ADDR_WIDTH-1:0]  opc_q, opc_d;
    logic                   valid_q, valid_d;
    logic                   mis_q, mis_d;
    logic                   fire;

    // Fetch when the output slot is empty or is being drained this cycle.
    assign fire = !valid_q || bus.i_ready;

    // NOTE: every _d gets its hold value first, so no branch can leave one
    // unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        opc_d   = opc_q;
        valid_d = valid_q;
        mis_d   = mis_q;

        if (bus.i_redirect) begin
            // Redirect beats fetch and stall; the held/in-flight word is dropped.
            valid_d = 1'b0;
            if (bus.i_redirect_pc[1:0] == 2'b00) begin
                pc_d    = bus.i_redirect_pc;
                mis_d   = 1'b0;
                state_d = RUN;
            end else begin
                mis_d   = 1'b1;
                state_d = FAULT;
            end
        end else begin
            unique case (state_q)
                RUN: begin
                    if (fire) begin
                        inst_d  = bus.i_imem_inst;
                        opc_d   = pc_q;
                        valid_d = 1'b1;
                        // Wraps modulo 2^ADDR_WIDTH by construction.
                        pc_d    = pc_q + ADDR_WIDTH'(4);
                    end
                end
                FAULT: begin
                    // Frozen until an aligned redirect or reset.
                end
                default: state_d = RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            opc_q   <= '0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            opc_q   <= opc_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
        end
    end

    assign bus.o_imem_addr  = pc_q;
    assign bus.o_inst       = inst_q;
    assign bus.o_pc         = opc_q;
    assign bus.o_valid      = valid_q;
    assign bus.o_misaligned = mis_q;
endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a cycle-by-cycle vector table covering
// reset, streaming, stall, redirect, misaligned fault, back-to-back redirects
// and PC wrap, followed by hand-written reset-mid-stall and reset-mid-fault
// sequences. Inputs change on the falling edge; outputs are sampled 1 time
// unit after the rising edge.

`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module tb_inst_fetch;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    inst_fetch_if #(.ADDR_WIDTH(10)) bus ();

    inst_fetch #(
        .MEM_SIZE (1024),
        .RESET_PC (10'h000)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.master)
    );

    // Instruction memory model: 256 words, combinational read.
    logic [31:0] mem [0:255];
    assign bus.i_imem_inst = mem[bus.o_imem_addr[9:2]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst_n;
        logic        ready;
        logic        redirect;
        logic [9:0]  rpc;
        logic        exp_valid;
        logic [31:0] exp_inst;
        logic [9:0]  exp_pc;
        logic [9:0]  exp_addr;
        logic        exp_mis;
        logic        chk_data;
        string       tag;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic rdy, logic rd, logic [9:0] rpc,
                                logic ev, logic [31:0] ei, logic [9:0] ep,
                                logic [9:0] ea, logic em, logic cd, string t);
        vec_t v;
        v.rst_n = r;  v.ready = rdy; v.redirect = rd; v.rpc = rpc;
        v.exp_valid = ev; v.exp_inst = ei; v.exp_pc = ep; v.exp_addr = ea;
        v.exp_mis = em; v.chk_data = cd; v.tag = t;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // NOTE: bench inputs are driven with blocking assignments on the falling
    // edge, so the DUT sees stable values at the next rising edge.
    task automatic step(input logic r, input logic rdy, input logic rd, input logic [9:0] rpc);
        @(negedge clk);
        rst_n             = r;
        bus.i_ready       = rdy;
        bus.i_redirect    = rd;
        bus.i_redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string t, input logic ev, input logic [31:0] ei,
                              input logic [9:0] ep, input logic [9:0] ea,
                              input logic em, input logic cd);
        check({t, ".valid"}, 32'(bus.o_valid), 32'(ev));
        check({t, ".addr"},  32'(bus.o_imem_addr), 32'(ea));
        check({t, ".mis"},   32'(bus.o_misaligned), 32'(em));
        if (cd) begin
            check({t, ".inst"}, bus.o_inst, ei);
            check({t, ".pc"},   32'(bus.o_pc), 32'(ep));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = 32'h00108113;
        mem[1] = 32'h00108193;
        mem[2] = 32'h00310233;
        mem[3] = 32'hfe218ae3;
        mem[4] = 32'h00000000;

        rst_n             = 1'b0;
        bus.i_ready       = 1'b0;
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = '0;

        //                rst rdy rd  rpc      val inst          pc      addr    mis dat tag
        // Reset, including a misaligned redirect that reset must override.
        vecs.push_back(mk(0, 1, 1, 10'h006,  0, 32'h0,        10'h000, 10'h000, 0, 1, "rst_redir"));
        vecs.push_back(mk(0, 0, 0, 10'h000,  0, 32'h0,        10'h000, 10'h000, 0, 1, "rst"));
        // Streaming from reset.
        vecs.push_back(mk(1, 1, 0, 10'h000,  1, 32'h00108113, 10'h000, 10'h004, 0, 1, "s0"));
        vecs.push_back(mk(1, 1, 0, 10'h000,  1, 32'h00108193, 10'h004, 10'h008, 0, 1, "s1"));
        vecs.push_back(mk(1, 1, 0, 10'h000,  1, 32'h00310233, 10'h008, 10'h00C, 0, 1, "s2"));
        vecs.push_back(mk(1, 1, 0, 10'h000,  1, 32'hfe218ae3, 10'h00C, 10'h010, 0, 1, "s3"));
        vecs.push_back(mk(1, 1, 0, 10'h000,  1, 32'h00000000, 10'h010, 10'h014, 0, 1, "s4"));
        // Redirect back to 0 (ready=1 in the same cycle still flushes).
        vecs.push_back(mk(1, 1, 1, 10'h000,  0, 32'h0,        10'h000, 10'h000, 0, 0, "rd0"));
        vecs.push_back(mk(1, 1, 0, 10'h000,  1, 32'h00108113, 10'h000, 10'h004, 0, 1, "rd0_a"));
        vecs.push_back(mk(1, 1, 0, 10'h000,  1, 32'h00108193, 10'h004, 10'h008, 0, 1, "rd0_b"));
        // Stall three cycles on 00108193, then resume with no skip/duplicate.
        vecs.push_back(mk(1, 0, 0, 10'h000,  1, 32'h00108193, 10'h004, 10'h008, 0, 1, "stall1"));
        vecs.push_back(mk(1, 0, 0, 10'h000,  1, 32'h00108193, 10'h004, 10'h008, 0, 1, "stall2"));
        vecs.push_back(mk(1, 0, 0, 10'h000,  1, 32'h00108193, 10'h004, 10'h008, 0, 1, "stall3"));
        vecs.push_back(mk(1, 1, 0, 10'h000,  1, 32'h00310233, 10'h008, 10'h00C, 0, 1, "resume"));
        // Get o_pc back to 0x004, then redirect to 0x00C while stalled.
        vecs.push_back(mk(1, 1, 1, 10'h000,  0, 32'h0,        10'h000, 10'h000, 0, 0, "rd1"));
        vecs.push_back(mk(1, 1, 0, 10'h000,  1, 32'h00108113, 10'h000, 10'h004, 0, 1, "rd1_a"));
        vecs.push_back(mk(1, 1, 0, 10'h000,  1, 32'h00108193, 10'h004, 10'h008, 0, 1, "rd1_b"));
        vecs.push_back(mk(1, 0, 1, 10'h00C,  0, 32'h0,        10'h000, 10'h00C, 0, 0, "rdC"));
        vecs.push_back(mk(1, 0, 0, 10'h000,  1, 32'hfe218ae3, 10'h00C, 10'h010, 0, 1, "rdC_a"));
        // Misaligned redirect: PC frozen at 0x010, no fetch while in FAULT.
        vecs.push_back(mk(1, 1, 1, 10'h006,  0, 32'h0,        10'h000, 10'h010, 1, 0, "mis"));
        vecs.push_back(mk(1, 1, 0, 10'h000,  0, 32'h0,        10'h000, 10'h010, 1, 0, "fault1"));
        vecs.push_back(mk(1, 1, 0, 10'h000,  0, 32'h0,        10'h000, 10'h010, 1, 0, "fault2"));
        vecs.push_back(mk(1, 1, 1, 10'h000,  0, 32'h0,        10'h000, 10'h000, 0, 0, "unfault"));
        vecs.push_back(mk(1, 1, 0, 10'h000,  1, 32'h00108113, 10'h000, 10'h004, 0, 1, "unfault_a"));
        // Back-to-back redirects: the last one wins; then wrap past 0x3FC.
        vecs.push_back(mk(1, 1, 1, 10'h008,  0, 32'h0,        10'h000, 10'h008, 0, 0, "b2b1"));
        vecs.push_back(mk(1, 1, 1, 10'h3FC,  0, 32'h0,        10'h000, 10'h3FC, 0, 0, "b2b2"));
        vecs.push_back(mk(1, 1, 0, 10'h000,  1, 32'h00000000, 10'h3FC, 10'h000, 0, 1, "wrap0"));
        vecs.push_back(mk(1, 1, 0, 10'h000,  1, 32'h00108113, 10'h000, 10'h004, 0, 1, "wrap1"));
        vecs.push_back(mk(1, 1, 0, 10'h000,  1, 32'h00108193, 10'h004, 10'h008, 0, 1, "wrap2"));

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].ready, vecs[i].redirect, vecs[i].rpc);
            check_outs(vecs[i].tag, vecs[i].exp_valid, vecs[i].exp_inst, vecs[i].exp_pc,
                       vecs[i].exp_addr, vecs[i].exp_mis, vecs[i].chk_data);
        end

        // Reset mid-stall: o_valid=1 holding 00108193, decode not ready.
        step(1, 0, 0, 10'h000);
        check_outs("pre_rst_stall", 1, 32'h00108193, 10'h004, 10'h008, 0, 1);
        step(0, 0, 1, 10'h00C);
        check_outs("rst_stall", 0, 32'h0, 10'h000, 10'h000, 0, 1);
        step(1, 0, 0, 10'h000);
        check_outs("rst_stall_rel", 1, 32'h00108113, 10'h000, 10'h004, 0, 1);

        // Reset while in FAULT clears the sticky flag and restarts fetch.
        step(1, 1, 1, 10'h002);
        check_outs("mis2", 0, 32'h0, 10'h000, 10'h004, 1, 0);
        step(0, 1, 0, 10'h000);
        check_outs("rst_fault", 0, 32'h0, 10'h000, 10'h000, 0, 1);
        step(1, 1, 0, 10'h000);
        check_outs("rst_fault_rel", 1, 32'h00108113, 10'h000, 10'h004, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
